// File: rtl/fft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_sequencer_if
//  Purpose  : Bundles the stream buses around the FFT frame sequencer:
//             the incoming sample stream, the core configuration stream,
//             the outgoing sample stream to the core and the snooped result
//             stream of the core.
//  Modports : master - the sequencer side
//             slave  - the environment side (source, core, result monitor)
//  Revision : 1.0 - initial release
// ============================================================================
interface fft_frame_sequencer_if #(
    parameter int DATA_W = 32
) ();
    // input sample stream
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    // core configuration stream
    logic [15:0]       m_axis_cfg_tdata;
    logic              m_axis_cfg_tvalid;
    logic              m_axis_cfg_tready;
    // sample stream to the core
    logic [DATA_W-1:0] m_axis_fft_tdata;
    logic              m_axis_fft_tvalid;
    logic              m_axis_fft_tready;
    logic              m_axis_fft_tlast;
    // snooped core result stream
    logic              mon_tvalid;
    logic              mon_tready;
    logic              mon_tlast;

    modport master (
        input  s_axis_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_cfg_tdata, m_axis_cfg_tvalid,
        input  m_axis_cfg_tready,
        output m_axis_fft_tdata, m_axis_fft_tvalid, m_axis_fft_tlast,
        input  m_axis_fft_tready,
        input  mon_tvalid, mon_tready, mon_tlast
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_cfg_tdata, m_axis_cfg_tvalid,
        output m_axis_cfg_tready,
        input  m_axis_fft_tdata, m_axis_fft_tvalid, m_axis_fft_tlast,
        output m_axis_fft_tready,
        output mon_tvalid, mon_tready, mon_tlast
    );
endinterface
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_frame_sequencer
//  Purpose  : Sequences sample frames into a streaming FFT core. Sends one
//             configuration word whenever a reconfiguration is pending,
//             then forwards samples in frames of 2^L beats with tlast on the
//             final beat, limiting the number of frames whose results have
//             not yet come back from the core.
//  Ports    : ACLK, ARESET        - clock, asynchronous active-high reset
//             enable              - permits new frames to start
//             cfg_log2n/fwd_inv/
//             cfg_scale/cfg_update- requested configuration + update pulse
//             bus (master)        - sample in, config out, sample out,
//                                   snooped result stream
//             busy                - sequencer not idle
//             inflight            - frames outstanding in the core
//             frame_done          - pulse per completed result frame
//             err_unexpected      - sticky: result frame with none outstanding
//  Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
    parameter int DATA_W       = 32,
    parameter int LOG2N_MAX    = 12,
    parameter int MAX_INFLIGHT = 4
) (
    input  wire logic                 ACLK,
    input  wire logic                 ARESET,
    input  wire logic                 enable,
    input  wire logic [3:0]           cfg_log2n,
    input  wire logic                 cfg_fwd_inv,
    input  wire logic [10:0]          cfg_scale,
    input  wire logic                 cfg_update,
    fft_frame_sequencer_if.master     bus,
    output logic                      busy,
    output logic [2:0]                inflight,
    output logic                      frame_done,
    output logic                      err_unexpected
);

    localparam logic [3:0] c_log2n_min    = 4'd3;
    localparam logic [3:0] c_log2n_max    = 4'(LOG2N_MAX);
    localparam logic [2:0] c_max_inflight = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONFIG = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_cfg_pending;
    logic [3:0]             r_log2n;
    logic                   r_fwd_inv;
    logic [10:0]            r_scale;
    logic [LOG2N_MAX-1:0]   r_cnt;
    logic [2:0]             r_inflight;
    logic                   r_frame_done;
    logic                   r_err;

    logic [3:0]             w_log2n_clamped;
    logic                   w_cfg_entry;
    logic                   w_cfg_hs;
    logic                   w_gate;
    logic                   w_tlast;
    logic                   w_fft_hs;
    logic                   w_tlast_hs;
    logic                   w_res_end;
    logic [LOG2N_MAX-1:0]   w_last_idx;
    logic [2:0]             w_inflight_nxt;
    logic [DATA_W-1:0]      w_sample;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_log2n_clamped = cfg_log2n;
        if (cfg_log2n < c_log2n_min) begin
            w_log2n_clamped = c_log2n_min;
        end else if (cfg_log2n > c_log2n_max) begin
            w_log2n_clamped = c_log2n_max;
        end
    end

    // Index of the final beat: the low L bits set.
    always_comb begin
        w_last_idx = '0;
        for (int i = 0; i < LOG2N_MAX; i++) begin
            w_last_idx[i] = (i < int'(r_log2n));
        end
    end

    assign w_cfg_entry = (r_state == S_IDLE) && enable && r_cfg_pending;
    assign w_cfg_hs    = (r_state == S_CONFIG) && bus.m_axis_cfg_tready;
    assign w_gate      = (r_state == S_STREAM) && (r_inflight < c_max_inflight);
    // tlast is qualified by STREAM so the idle counter value never leaks out
    assign w_tlast     = (r_state == S_STREAM) && (r_cnt == w_last_idx);
    assign w_fft_hs    = bus.s_axis_tvalid && w_gate && bus.m_axis_fft_tready;
    assign w_tlast_hs  = w_fft_hs && w_tlast;
    assign w_res_end   = bus.mon_tvalid && bus.mon_tready && bus.mon_tlast;

    assign w_sample              = bus.s_axis_tdata;
    assign bus.m_axis_fft_tdata  = (r_state == S_STREAM) ? w_sample : '0;
    assign bus.m_axis_fft_tvalid = bus.s_axis_tvalid && w_gate;
    assign bus.m_axis_fft_tlast  = w_tlast;
    assign bus.s_axis_tready     = bus.m_axis_fft_tready && w_gate;

    assign bus.m_axis_cfg_tvalid = (r_state == S_CONFIG);
    assign bus.m_axis_cfg_tdata  = {r_scale, r_fwd_inv, r_log2n};

    assign busy           = (r_state != S_IDLE);
    assign inflight       = r_inflight;
    assign frame_done     = r_frame_done;
    assign err_unexpected = r_err;

    // An issue and a return in the same cycle cancel out.
    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_tlast_hs && !w_res_end) begin
            w_inflight_nxt = r_inflight + 3'd1;
        end else if (!w_tlast_hs && w_res_end && (r_inflight != 3'd0)) begin
            w_inflight_nxt = r_inflight - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = r_cfg_pending ? S_CONFIG : S_STREAM;
                end
            end
            S_CONFIG: begin
                if (w_cfg_hs) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                // Frames are never cut short; the decision waits for tlast.
                if (w_tlast_hs && (r_cfg_pending || cfg_update || !enable)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_inflight == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Configuration latch and pending flag
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cfg_pending <= 1'b1;
            r_log2n       <= 4'd0;
            r_fwd_inv     <= 1'b0;
            r_scale       <= 11'd0;
        end else begin
            // A new request wins over a handshake in the same cycle.
            if (cfg_update) begin
                r_cfg_pending <= 1'b1;
            end else if (w_cfg_hs) begin
                r_cfg_pending <= 1'b0;
            end
            if (w_cfg_entry) begin
                r_log2n   <= w_log2n_clamped;
                r_fwd_inv <= cfg_fwd_inv;
                r_scale   <= cfg_scale;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat counter, inflight tracking and status
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cnt        <= '0;
            r_inflight   <= 3'd0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_fft_hs) begin
                r_cnt <= w_tlast ? '0 : r_cnt + LOG2N_MAX'(1);
            end
            r_inflight   <= w_inflight_nxt;
            r_frame_done <= w_res_end && (w_tlast_hs || (r_inflight != 3'd0));
            if (w_res_end && !w_tlast_hs && (r_inflight == 3'd0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_frame_sequencer
//  Purpose  : Self-checking bench for fft_frame_sequencer. Sample beats and
//             configuration words are queued as expected values when the
//             stimulus is driven and compared when the DUT hands them over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;

    localparam int DW = 32;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  cfg_log2n = 4'd0;
    logic        cfg_fwd_inv = 1'b0;
    logic [10:0] cfg_scale = 11'd0;
    logic        cfg_update = 1'b0;
    logic        busy;
    logic [2:0]  inflight;
    logic        frame_done;
    logic        err_unexpected;

    fft_frame_sequencer_if #(.DATA_W(DW)) bus ();

    fft_frame_sequencer #(
        .DATA_W       (DW),
        .LOG2N_MAX    (12),
        .MAX_INFLIGHT (4)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .enable         (enable),
        .cfg_log2n      (cfg_log2n),
        .cfg_fwd_inv    (cfg_fwd_inv),
        .cfg_scale      (cfg_scale),
        .cfg_update     (cfg_update),
        .bus            (bus),
        .busy           (busy),
        .inflight       (inflight),
        .frame_done     (frame_done),
        .err_unexpected (err_unexpected)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0]  log2n;
        logic        fwd;
        logic [10:0] scale;
        logic [15:0] word;
        int          beats;
    } vec_t;

    beat_t       sb_q[$];
    logic [15:0] cfg_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboard side: compare whatever the DUT hands over.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bus.m_axis_fft_tvalid && bus.m_axis_fft_tready) begin
                if (sb_q.size() == 0) begin
                    chk("fft_extra_beat", 64'(sb_q.size()), 64'd1);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("fft_beat", {bus.m_axis_fft_tdata, bus.m_axis_fft_tlast}, {e.data, e.last});
                end
            end
            if (bus.m_axis_cfg_tvalid && bus.m_axis_cfg_tready) begin
                if (cfg_q.size() == 0) begin
                    chk("cfg_extra_word", 64'(cfg_q.size()), 64'd1);
                end else begin
                    logic [15:0] w;
                    w = cfg_q.pop_front();
                    chk("cfg_word", bus.m_axis_cfg_tdata, w);
                end
            end
        end
    end

    task automatic set_mon(input logic v);
        bus.mon_tvalid = v;
        bus.mon_tready = v;
        bus.mon_tlast  = v;
    endtask

    task automatic wait_accept();
        int t = 0;
        @(negedge ACLK);
        while (!bus.s_axis_tready) begin
            t++;
            if (t > 200) begin
                chk("s_axis_tready_timeout", bus.s_axis_tready, 1);
                break;
            end
            @(negedge ACLK);
        end
        @(posedge ACLK);
        #1;
    endtask

    // Drives a frame of n beats (or only the first stop_at beats), queuing
    // the expected core-side beats as it goes.
    task automatic send_frame(input int n, input logic [31:0] base, input int upd_beat,
                              input logic [3:0] upd_log2n, input bit mon_last, input int stop_at);
        int lim;
        lim = (stop_at >= 0) ? stop_at : n;
        for (int b = 0; b < lim; b++) begin
            sb_q.push_back('{data: base + 32'(b), last: (b == n - 1)});
            bus.s_axis_tdata  = base + 32'(b);
            bus.s_axis_tvalid = 1'b1;
            if (b == upd_beat) begin
                cfg_update = 1'b1;
                cfg_log2n  = upd_log2n;
            end
            if (mon_last && (b == n - 1)) set_mon(1'b1);
            wait_accept();
            cfg_update = 1'b0;
            set_mon(1'b0);
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic mon_pulse(input logic exp_done, input logic [2:0] exp_infl);
        set_mon(1'b1);
        step();
        set_mon(1'b0);
        chk("frame_done", frame_done, exp_done);
        chk("inflight_after_result", inflight, exp_infl);
        step();
        chk("frame_done_one_cycle", frame_done, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 50) begin
            step();
            t++;
        end
        chk("return_to_idle", busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, bus.s_axis_tready, 0);
        chk({tag, "_cfg_tvalid"}, bus.m_axis_cfg_tvalid, 0);
        chk({tag, "_cfg_tdata"}, bus.m_axis_cfg_tdata, 0);
        chk({tag, "_fft_tvalid"}, bus.m_axis_fft_tvalid, 0);
        chk({tag, "_fft_tdata"}, bus.m_axis_fft_tdata, 0);
        chk({tag, "_fft_tlast"}, bus.m_axis_fft_tlast, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_inflight"}, inflight, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err"}, err_unexpected, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{log2n: 4'd0, fwd: 1'b1, scale: 11'h123, word: 16'h2473, beats: 8};
        vecs[1] = '{log2n: 4'd2, fwd: 1'b0, scale: 11'h000, word: 16'h0003, beats: 8};
        vecs[2] = '{log2n: 4'd4, fwd: 1'b0, scale: 11'h555, word: 16'hAAA4, beats: 16};
        vecs[3] = '{log2n: 4'd6, fwd: 1'b1, scale: 11'h7FF, word: 16'hFFF6, beats: 64};
        vecs[4] = '{log2n: 4'd5, fwd: 1'b1, scale: 11'h0AB, word: 16'h1575, beats: 32};

        // ---------------- reset with busy-looking inputs ----------------
        ARESET = 1'b1;
        bus.s_axis_tdata      = 32'hFFFF_FFFF;
        bus.s_axis_tvalid     = 1'b1;
        bus.m_axis_cfg_tready = 1'b1;
        bus.m_axis_fft_tready = 1'b1;
        set_mon(1'b1);
        enable = 1'b1;
        step();
        step();
        chk_reset_outputs("reset");
        bus.s_axis_tvalid = 1'b0;
        set_mon(1'b0);
        enable = 1'b0;
        ARESET = 1'b0;
        step();

        // ---------------- table: clamp and config word packing ----------
        for (int i = 0; i < 5; i++) begin
            cfg_log2n   = vecs[i].log2n;
            cfg_fwd_inv = vecs[i].fwd;
            cfg_scale   = vecs[i].scale;
            cfg_update  = 1'b1;
            step();
            cfg_update = 1'b0;
            cfg_q.push_back(vecs[i].word);
            enable = 1'b1;
            step();
            enable = 1'b0;
            chk("busy_after_enable", busy, 1);
            send_frame(vecs[i].beats, 32'h1000 * 32'(i), -1, 4'd0, 1'b0, -1);
            chk("inflight_after_frame", inflight, 1);
            mon_pulse(1'b1, 3'd0);
            wait_idle();
        end

        // ---------------- config held under backpressure ----------------
        bus.m_axis_cfg_tready = 1'b0;
        cfg_log2n   = 4'd3;
        cfg_fwd_inv = 1'b1;
        cfg_scale   = 11'd0;
        cfg_update  = 1'b1;
        step();
        cfg_update = 1'b0;
        enable = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 32'hDEAD_BEEF;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("cfg_tvalid_held", bus.m_axis_cfg_tvalid, 1);
            chk("cfg_tdata_held", bus.m_axis_cfg_tdata, 16'h0013);
            chk("s_tready_in_config", bus.s_axis_tready, 0);
            cfg_log2n = 4'(9 + c);
            step();
        end
        bus.s_axis_tvalid = 1'b0;
        cfg_q.push_back(16'h0013);
        bus.m_axis_cfg_tready = 1'b1;

        // ---------------- basic 8-beat frame ----------------------------
        send_frame(8, 32'hA000, -1, 4'd0, 1'b0, -1);
        chk("inflight_one_frame", inflight, 1);
        chk("busy_streaming", busy, 1);

        // ---------------- inflight limit --------------------------------
        for (int f = 0; f < 3; f++) send_frame(8, 32'hB000 + 32'(16 * f), -1, 4'd0, 1'b0, -1);
        chk("inflight_full", inflight, 4);
        bus.s_axis_tvalid = 1'b1;
        #1;
        chk("s_tready_full", bus.s_axis_tready, 0);
        chk("fft_tvalid_full", bus.m_axis_fft_tvalid, 0);
        step();
        chk("s_tready_full_2", bus.s_axis_tready, 0);
        bus.s_axis_tvalid = 1'b0;
        mon_pulse(1'b1, 3'd3);
        chk("s_tready_resumes", bus.s_axis_tready, 1);
        send_frame(8, 32'hC000, -1, 4'd0, 1'b0, -1);
        chk("inflight_refilled", inflight, 4);
        mon_pulse(1'b1, 3'd3);
        mon_pulse(1'b1, 3'd2);
        mon_pulse(1'b1, 3'd1);
        mon_pulse(1'b1, 3'd0);

        // ---------------- unexpected result and simultaneous events -----
        mon_pulse(1'b0, 3'd0);
        chk("err_set", err_unexpected, 1);
        step();
        chk("err_sticky", err_unexpected, 1);
        send_frame(8, 32'hD000, -1, 4'd0, 1'b0, -1);
        send_frame(8, 32'hD100, -1, 4'd0, 1'b1, -1);
        chk("inflight_simultaneous", inflight, 1);
        chk("frame_done_simultaneous", frame_done, 1);
        chk("err_still_set", err_unexpected, 1);
        step();
        chk("frame_done_simul_clear", frame_done, 0);
        mon_pulse(1'b1, 3'd0);

        // ---------------- reconfiguration mid-frame ---------------------
        cfg_log2n  = 4'd4;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        cfg_q.push_back(16'h0014);
        send_frame(8, 32'hE000, -1, 4'd0, 1'b0, -1);
        mon_pulse(1'b1, 3'd0);
        cfg_q.push_back(16'h0015);
        send_frame(16, 32'hE100, 2, 4'd5, 1'b0, -1);
        for (int c = 0; c < 3; c++) begin
            chk("drain_busy", busy, 1);
            chk("drain_inflight", inflight, 1);
            chk("drain_no_cfg", bus.m_axis_cfg_tvalid, 0);
            chk("drain_s_tready", bus.s_axis_tready, 0);
            step();
        end
        mon_pulse(1'b1, 3'd0);
        send_frame(32, 32'hE200, -1, 4'd0, 1'b0, -1);
        send_frame(32, 32'hE300, -1, 4'd0, 1'b0, -1);
        chk("inflight_two_32", inflight, 2);
        mon_pulse(1'b1, 3'd1);
        mon_pulse(1'b1, 3'd0);

        // ---------------- reset mid-frame, oversize request -------------
        send_frame(32, 32'hF000, -1, 4'd0, 1'b0, 5);
        bus.s_axis_tvalid = 1'b1;
        set_mon(1'b1);
        ARESET = 1'b1;
        #1;
        chk_reset_outputs("midframe_reset");
        step();
        chk_reset_outputs("midframe_reset_2");
        bus.s_axis_tvalid = 1'b0;
        set_mon(1'b0);
        cfg_log2n   = 4'd15;
        cfg_fwd_inv = 1'b0;
        cfg_scale   = 11'h3FF;
        cfg_q.push_back(16'h7FEC);
        ARESET = 1'b0;
        step();
        chk("err_cleared_by_reset", err_unexpected, 0);
        send_frame(4096, 32'h0010_0000, -1, 4'd0, 1'b0, -1);
        chk("inflight_after_4096", inflight, 1);
        mon_pulse(1'b1, 3'd0);

        step();
        chk("beat_queue_empty", 64'(sb_q.size()), 0);
        chk("cfg_queue_empty", 64'(cfg_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample data width.
REQ-002 SHALL have parameter LOG2N_MAX, default 12, meaning the largest supported transform size, log2.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, meaning the largest number of frames issued to the core whose results have not yet returned.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have these ports, in this order:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous reset, active-high.
- enable  in  1  level; permits new frames to start.
- cfg_log2n  in  4  requested transform size, log2.
- cfg_fwd_inv  in  1  1 = forward transform, 0 = inverse.
- cfg_scale  in  11  scaling schedule for the core.
- cfg_update  in  1  one-cycle pulse requesting reconfiguration.
- s_axis_tdata  in  DATA_W  input sample stream, data.
- s_axis_tvalid  in  1  input sample stream, valid.
- s_axis_tready  out  1  input sample stream, ready.
- m_axis_cfg_tdata  out  16  core configuration word.
- m_axis_cfg_tvalid  out  1  core configuration, valid.
- m_axis_cfg_tready  in  1  core configuration, ready.
- m_axis_fft_tdata  out  DATA_W  sample stream to core, data.
- m_axis_fft_tvalid  out  1  sample stream to core, valid.
- m_axis_fft_tready  in  1  sample stream to core, ready.
- m_axis_fft_tlast  out  1  sample stream to core, last beat of frame.
- mon_tvalid  in  1  snooped core result stream, valid.
- mon_tready  in  1  snooped core result stream, ready.
- mon_tlast  in  1  snooped core result stream, last.
- busy  out  1  state is not IDLE.
- inflight  out  3  count of frames outstanding in the core.
- frame_done  out  1  one-cycle pulse when a result frame completes.
- err_unexpected  out  1  sticky; a result frame ended while inflight was 0.

Function
REQ-006 SHALL implement states IDLE, CONFIG, STREAM and DRAIN.
REQ-007 SHALL keep an internal cfg_pending flag that is set by reset and by cfg_update, and is cleared when the configuration handshake completes.
REQ-008 IDLE SHALL move to CONFIG when enable=1 and cfg_pending=1, SHALL move to STREAM when enable=1 and cfg_pending=0, and otherwise SHALL stay in IDLE.
REQ-009 On entry to CONFIG, SHALL latch the effective size L = clamp(cfg_log2n, 3, LOG2N_MAX), together with cfg_fwd_inv and cfg_scale.
REQ-010 In CONFIG, SHALL drive m_axis_cfg_tvalid=1 with m_axis_cfg_tdata = {scale[10:0], fwd_inv, L[3:0]}, and SHALL hold both stable until m_axis_cfg_tready=1.
REQ-011 A config handshake SHALL move the state to STREAM on the next cycle.
REQ-012 In STREAM, the sample path SHALL be combinational:
- m_axis_fft_tdata = s_axis_tdata.
- m_axis_fft_tvalid = s_axis_tvalid AND gate.
- s_axis_tready = m_axis_fft_tready AND gate.
- gate = (state==STREAM) AND (inflight<MAX_INFLIGHT).
REQ-013 SHALL keep a sample counter of width LOG2N_MAX that increments on each handshake on the core sample stream.
REQ-014 SHALL assert m_axis_fft_tlast while the counter equals 2^L-1, and on that beat the counter SHALL wrap to 0.
REQ-015 On a tlast handshake, inflight SHALL increment; then SHALL go to DRAIN if cfg_pending=1 or enable=0, and otherwise SHALL stay in STREAM.
REQ-016 A cfg_update or a deassertion of enable mid-frame SHALL NOT truncate the frame; the current frame SHALL complete with exactly 2^L beats.
REQ-017 DRAIN SHALL move to IDLE in the cycle after inflight reaches 0.
REQ-018 A monitor beat with mon_tvalid, mon_tready and mon_tlast all 1 SHALL end a result frame.
REQ-019 When a result frame ends and inflight>0, inflight SHALL decrement and frame_done SHALL pulse for one cycle.
REQ-020 When a result frame ends and inflight=0, err_unexpected SHALL set, inflight SHALL stay 0, and frame_done SHALL stay 0.
REQ-021 A tlast handshake and a result-frame end in the same cycle SHALL leave inflight unchanged, and frame_done SHALL still pulse.
REQ-022 Changes on cfg_* outside CONFIG entry SHALL have no effect on the active configuration.
REQ-023 A cfg_update arriving in the same cycle as the config handshake SHALL leave cfg_pending=1.

Reset
REQ-024 While ARESET=1, SHALL hold:
- state = IDLE.
- cfg_pending = 1.
- sample counter = 0.
- inflight = 0.
- err_unexpected = 0.
- every output = 0, including s_axis_tready, m_axis_cfg_tvalid, m_axis_fft_tvalid, m_axis_fft_tlast, busy and frame_done.
REQ-025 A reset during an active frame SHALL abandon that frame, and after reset the next frame SHALL be preceded by a CONFIG handshake.

Verification
REQ-026 Bench SHALL drive cfg_log2n=3, enable=1, with all tready held 1 -> one config word 0x....3, then 8 beats with tlast on beat 8, and inflight=1.
REQ-027 Bench SHALL hold m_axis_cfg_tready=0 for 5 cycles -> tvalid and tdata held stable, and s_axis_tready=0 throughout.
REQ-028 Bench SHALL run 4 frames with mon_tvalid held 0 (MAX_INFLIGHT=4) -> inflight=4 and s_axis_tready=0; then one result tlast -> frame_done pulse and streaming resumes.
REQ-029 Bench SHALL pulse cfg_update at beat 3 of a 16-beat frame (log2n=4) and set new log2n=5 -> frame ends at beat 16, DRAIN until inflight=0, new config word, then 32-beat frames.
REQ-030 Bench SHALL issue a result tlast with inflight=0 -> err_unexpected=1 and stays 1; then a simultaneous tlast handshake and result end -> inflight unchanged.
REQ-031 Bench SHALL assert ARESET at beat 5 of a frame, and apply cfg_log2n=15 after reset -> all outputs 0 during reset; then a config word with L=12 and 4096-beat frames.
